// File: rtl/alu_sequencer_if.sv
// Instruction handshake plus register-file and ALU control bundle for alu_sequencer.
// The master modport is the sequencer side; the slave modport is its environment.
interface alu_sequencer_if;
    localparam int unsigned INSTR_W  = 14;
    localparam int unsigned ADDR_W   = 7;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned OP_W     = 4;
    localparam int unsigned RETIRE_W = 16;

    logic [INSTR_W-1:0]  instr;
    logic                instr_valid;
    logic                instr_ready;
    logic [ADDR_W-1:0]   rf_addr;
    logic                rf_rd_en;
    logic [DATA_W-1:0]   rf_rd_data;
    logic [OP_W-1:0]     alu_op;
    logic [DATA_W-1:0]   alu_lf;
    logic                alu_d;
    logic                alu_d_wr_en;
    logic                alu_status_wr_en;
    logic [DATA_W-1:0]   alu_result;
    logic                unsupported;
    logic [RETIRE_W-1:0] retired;

    modport master (
        input  instr, instr_valid, rf_rd_data, alu_result,
        output instr_ready, rf_addr, rf_rd_en, alu_op, alu_lf, alu_d,
               alu_d_wr_en, alu_status_wr_en, unsupported, retired
    );

    modport slave (
        output instr, instr_valid, rf_rd_data, alu_result,
        input  instr_ready, rf_addr, rf_rd_en, alu_op, alu_lf, alu_d,
               alu_d_wr_en, alu_status_wr_en, unsupported, retired
    );
endinterface

// File: rtl/alu_sequencer.sv
// Four-phase (Q1..Q4) PIC16 ALU instruction sequencer: decodes byte/literal ops,
// fetches the file operand, strobes the ALU writes in Q4 and handles FSZ skips.
module alu_sequencer (
    input  logic            clk,
    input  logic            rst_n,
    alu_sequencer_if.master bus
);
    localparam int unsigned OP_W   = 4;
    localparam int unsigned DATA_W = 8;

    localparam logic [OP_W-1:0] OP_ADD    = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB    = 4'd1;
    localparam logic [OP_W-1:0] OP_AND    = 4'd2;
    localparam logic [OP_W-1:0] OP_OR     = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR    = 4'd4;
    localparam logic [OP_W-1:0] OP_COM    = 4'd5;
    localparam logic [OP_W-1:0] OP_INC    = 4'd6;
    localparam logic [OP_W-1:0] OP_DEC    = 4'd7;
    localparam logic [OP_W-1:0] OP_RLF    = 4'd8;
    localparam logic [OP_W-1:0] OP_RRF    = 4'd9;
    localparam logic [OP_W-1:0] OP_SWAPF  = 4'd10;
    localparam logic [OP_W-1:0] OP_CLR    = 4'd11;
    localparam logic [OP_W-1:0] OP_PASSLF = 4'd12;
    localparam logic [OP_W-1:0] OP_PASSW  = 4'd13;

    typedef enum logic [2:0] {S_IDLE, S_Q1, S_Q2, S_Q3, S_Q4} state_t;

    state_t            state;
    logic              accept_c;
    logic [OP_W-1:0]   dec_op;
    logic              dec_d, dec_wr, dec_st, dec_rd, dec_fsz, dec_unsup;
    logic              byte_q, lit_q, rd_q, wr_q, st_q, fsz_q, skip_pending;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] result_q;

    assign accept_c = bus.instr_valid & bus.instr_ready;

    // Decode of the instruction word presented on the bus (used only on accept)
    always_comb begin
        dec_op    = OP_ADD;
        dec_d     = 1'b0;
        dec_wr    = 1'b0;
        dec_st    = 1'b0;
        dec_rd    = 1'b0;
        dec_fsz   = 1'b0;
        dec_unsup = 1'b0;
        case (bus.instr[13:12])
            2'b00: begin
                dec_d  = bus.instr[7];
                dec_wr = 1'b1;
                dec_st = 1'b1;
                dec_rd = 1'b1;
                case (bus.instr[11:8])
                    4'b0111: dec_op = OP_ADD;
                    4'b0101: dec_op = OP_AND;
                    4'b0001: begin dec_op = OP_CLR; dec_rd = 1'b0; end
                    4'b1001: dec_op = OP_COM;
                    4'b0011: dec_op = OP_DEC;
                    4'b1011: begin dec_op = OP_DEC; dec_st = 1'b0; dec_fsz = 1'b1; end
                    4'b1010: dec_op = OP_INC;
                    4'b1111: begin dec_op = OP_INC; dec_st = 1'b0; dec_fsz = 1'b1; end
                    4'b0100: dec_op = OP_OR;
                    4'b1000: dec_op = OP_PASSLF;
                    4'b1101: dec_op = OP_RLF;
                    4'b1100: dec_op = OP_RRF;
                    4'b0010: dec_op = OP_SUB;
                    4'b1110: begin dec_op = OP_SWAPF; dec_st = 1'b0; end
                    4'b0110: dec_op = OP_XOR;
                    4'b0000: begin
                        dec_rd = 1'b0;
                        dec_st = 1'b0;
                        if (bus.instr[7]) dec_op = OP_PASSW;
                        else              dec_wr = 1'b0;
                    end
                endcase
            end
            2'b11: begin
                dec_wr = 1'b1;
                dec_st = 1'b1;
                casez (bus.instr[11:8])
                    4'b111?: dec_op = OP_ADD;
                    4'b110?: dec_op = OP_SUB;
                    4'b1001: dec_op = OP_AND;
                    4'b1000: dec_op = OP_OR;
                    4'b1010: dec_op = OP_XOR;
                    4'b00??: begin dec_op = OP_PASSLF; dec_st = 1'b0; end
                    default: begin dec_wr = 1'b0; dec_st = 1'b0; dec_unsup = 1'b1; end
                endcase
            end
            default: dec_unsup = 1'b1;
        endcase
    end

    // Phase sequencing with registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= S_IDLE;
            bus.instr_ready      <= 1'b1;
            bus.rf_addr          <= '0;
            bus.rf_rd_en         <= 1'b0;
            bus.alu_op           <= '0;
            bus.alu_lf           <= '0;
            bus.alu_d            <= 1'b0;
            bus.alu_d_wr_en      <= 1'b0;
            bus.alu_status_wr_en <= 1'b0;
            bus.unsupported      <= 1'b0;
            bus.retired          <= '0;
            byte_q               <= 1'b0;
            lit_q                <= 1'b0;
            rd_q                 <= 1'b0;
            wr_q                 <= 1'b0;
            st_q                 <= 1'b0;
            fsz_q                <= 1'b0;
            skip_pending         <= 1'b0;
            imm_q                <= '0;
            result_q             <= '0;
        end else begin
            bus.unsupported      <= 1'b0;
            bus.rf_rd_en         <= 1'b0;
            bus.alu_d_wr_en      <= 1'b0;
            bus.alu_status_wr_en <= 1'b0;
            case (state)
                S_IDLE, S_Q4: begin
                    // A skipped instruction consumes the pending skip; FSZ with zero arms one
                    if (state == S_Q4) begin
                        if (skip_pending)                      skip_pending <= 1'b0;
                        else if (fsz_q && result_q == 8'h00)   skip_pending <= 1'b1;
                    end
                    if (accept_c) begin
                        state           <= S_Q1;
                        bus.instr_ready <= 1'b0;
                        bus.rf_addr     <= bus.instr[6:0];
                        bus.alu_op      <= dec_op;
                        bus.alu_d       <= dec_d;
                        bus.unsupported <= dec_unsup;
                        byte_q          <= (bus.instr[13:12] == 2'b00);
                        lit_q           <= (bus.instr[13:12] == 2'b11);
                        rd_q            <= dec_rd;
                        wr_q            <= dec_wr;
                        st_q            <= dec_st;
                        fsz_q           <= dec_fsz;
                        imm_q           <= bus.instr[7:0];
                    end else begin
                        state           <= S_IDLE;
                        bus.instr_ready <= 1'b1;
                    end
                end
                S_Q1: begin
                    state        <= S_Q2;
                    bus.rf_rd_en <= rd_q & ~skip_pending;
                end
                S_Q2: begin
                    state <= S_Q3;
                    if (byte_q)     bus.alu_lf <= bus.rf_rd_data;
                    else if (lit_q) bus.alu_lf <= imm_q;
                end
                S_Q3: begin
                    state                <= S_Q4;
                    bus.instr_ready      <= 1'b1;
                    result_q             <= bus.alu_result;
                    bus.alu_d_wr_en      <= wr_q & ~skip_pending;
                    bus.alu_status_wr_en <= st_q & ~skip_pending;
                    bus.retired          <= bus.retired + 16'd1;
                end
                default: begin
                    state           <= S_IDLE;
                    bus.instr_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed, table-driven bench for alu_sequencer: per-phase strobe patterns,
// decoded ALU controls, FSZ skip behaviour, back-to-back timing and mid-instruction reset.
module tb_alu_sequencer;
    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,   OP_OR = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4,  OP_COM = 4'd5,  OP_INC = 4'd6,   OP_DEC = 4'd7;
    localparam logic [3:0] OP_RLF = 4'd8,  OP_RRF = 4'd9,  OP_SWAPF = 4'd10, OP_CLR = 4'd11;
    localparam logic [3:0] OP_PASSLF = 4'd12, OP_PASSW = 4'd13;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_sequencer_if bus ();
    alu_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [13:0] instr;
        logic [7:0]  rf;
        logic [7:0]  res;
        logic        chk_alu;
        logic [3:0]  op;
        logic [7:0]  lf;
        logic        d;
        logic        rd;
        logic        wr;
        logic        st;
        logic        uns;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_ret = 16'd0;

    logic [3:0]  cap_uns, cap_rd, cap_wr, cap_st;
    logic [3:0]  cap_op3, cap_op4;
    logic [7:0]  cap_lf3, cap_lf4;
    logic        cap_d3, cap_d4;
    logic [6:0]  cap_addr;
    logic [15:0] cap_ret;

    vec_t vecs [21];
    vec_t skv  [8];

    function automatic vec_t mk(input logic [13:0] ins, input logic [7:0] rf, input logic [7:0] res,
                                input logic chk, input logic [3:0] op, input logic [7:0] lf,
                                input logic d, input logic rd, input logic wr, input logic st,
                                input logic uns);
        vec_t v;
        v.instr = ins; v.rf = rf; v.res = res; v.chk_alu = chk; v.op = op; v.lf = lf;
        v.d = d; v.rd = rd; v.wr = wr; v.st = st; v.uns = uns;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one instruction at a negedge and record Q1..Q4 samples
    task automatic issue(input vec_t v);
        int n = 0;
        while (bus.instr_ready !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(bus.instr_ready), 32'd1);
        bus.instr       = v.instr;
        bus.rf_rd_data  = v.rf;
        bus.alu_result  = v.res;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            cap_uns[p] = bus.unsupported;
            cap_rd[p]  = bus.rf_rd_en;
            cap_wr[p]  = bus.alu_d_wr_en;
            cap_st[p]  = bus.alu_status_wr_en;
            if (p == 0) cap_addr = bus.rf_addr;
            if (p == 2) begin cap_op3 = bus.alu_op; cap_lf3 = bus.alu_lf; cap_d3 = bus.alu_d; end
            if (p == 3) begin
                cap_op4 = bus.alu_op; cap_lf4 = bus.alu_lf; cap_d4 = bus.alu_d;
                cap_ret = bus.retired;
            end
        end
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        check({tag, "_uns"},  32'(cap_uns), 32'({3'b000, v.uns}));
        check({tag, "_rd"},   32'(cap_rd),  32'({2'b00, v.rd, 1'b0}));
        check({tag, "_wr"},   32'(cap_wr),  32'({v.wr, 3'b000}));
        check({tag, "_st"},   32'(cap_st),  32'({v.st, 3'b000}));
        check({tag, "_addr"}, 32'(cap_addr), 32'(v.instr[6:0]));
        if (v.chk_alu) begin
            check({tag, "_op"}, 32'({cap_op3, cap_op4}), 32'({v.op, v.op}));
            check({tag, "_lf"}, 32'({cap_lf3, cap_lf4}), 32'({v.lf, v.lf}));
            check({tag, "_d"},  32'({cap_d3, cap_d4}),   32'({v.d, v.d}));
        end
        exp_ret = exp_ret + 16'd1;
        check({tag, "_retired"}, 32'(cap_ret), 32'(exp_ret));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] rmask;
        int          acc;
        logic        wr_seen, rdy_all;

        //                  instr     rf     res    chk op         lf     d  rd wr st uns
        vecs[0]  = mk(14'h07A0, 8'h05, 8'h0A, 1, OP_ADD,    8'h05, 1, 1, 1, 1, 0);
        vecs[1]  = mk(14'h303C, 8'h99, 8'h3C, 1, OP_PASSLF, 8'h3C, 0, 0, 1, 0, 0);
        vecs[2]  = mk(14'h0521, 8'hF0, 8'h00, 1, OP_AND,    8'hF0, 0, 1, 1, 1, 0);
        vecs[3]  = mk(14'h00A5, 8'h77, 8'h11, 1, OP_PASSW,  8'h77, 1, 0, 1, 0, 0);
        vecs[4]  = mk(14'h0185, 8'h11, 8'h00, 1, OP_CLR,    8'h11, 1, 0, 1, 1, 0);
        vecs[5]  = mk(14'h0E30, 8'h3C, 8'hC3, 1, OP_SWAPF,  8'h3C, 0, 1, 1, 0, 0);
        vecs[6]  = mk(14'h3A55, 8'h00, 8'h22, 1, OP_XOR,    8'h55, 0, 0, 1, 1, 0);
        vecs[7]  = mk(14'h3C10, 8'h00, 8'h33, 1, OP_SUB,    8'h10, 0, 0, 1, 1, 0);
        vecs[8]  = mk(14'h3E01, 8'h00, 8'h44, 1, OP_ADD,    8'h01, 0, 0, 1, 1, 0);
        vecs[9]  = mk(14'h0C81, 8'h81, 8'hC0, 1, OP_RRF,    8'h81, 1, 1, 1, 1, 0);
        vecs[10] = mk(14'h0FA2, 8'hFF, 8'h05, 1, OP_INC,    8'hFF, 1, 1, 1, 0, 0);
        vecs[11] = mk(14'h3812, 8'h00, 8'h12, 1, OP_OR,     8'h12, 0, 0, 1, 1, 0);
        vecs[12] = mk(14'h0910, 8'h0F, 8'hF0, 1, OP_COM,    8'h0F, 0, 1, 1, 1, 0);
        vecs[13] = mk(14'h0DA0, 8'h40, 8'h80, 1, OP_RLF,    8'h40, 1, 1, 1, 1, 0);
        vecs[14] = mk(14'h0320, 8'h02, 8'h01, 1, OP_DEC,    8'h02, 0, 1, 1, 1, 0);
        vecs[15] = mk(14'h0820, 8'h5A, 8'h5A, 1, OP_PASSLF, 8'h5A, 0, 1, 1, 1, 0);
        vecs[16] = mk(14'h0000, 8'h00, 8'h00, 0, OP_ADD,    8'h00, 0, 0, 0, 0, 0);
        vecs[17] = mk(14'h3400, 8'h00, 8'h00, 0, OP_ADD,    8'h00, 0, 0, 0, 0, 1);
        vecs[18] = mk(14'h1400, 8'h00, 8'h00, 0, OP_ADD,    8'h00, 0, 0, 0, 0, 1);
        vecs[19] = mk(14'h3B00, 8'h00, 8'h00, 0, OP_ADD,    8'h00, 0, 0, 0, 0, 1);
        vecs[20] = mk(14'h2000, 8'h00, 8'h00, 0, OP_ADD,    8'h00, 0, 0, 0, 0, 1);

        // DECFSZ hitting zero skips the next op; a skipped FSZ does not re-arm the skip
        skv[0] = mk(14'h0BA1, 8'h01, 8'h00, 1, OP_DEC, 8'h01, 1, 1, 1, 0, 0);
        skv[1] = mk(14'h3E01, 8'h00, 8'h02, 1, OP_ADD, 8'h01, 0, 0, 0, 0, 0);
        skv[2] = mk(14'h3E01, 8'h00, 8'h02, 1, OP_ADD, 8'h01, 0, 0, 1, 1, 0);
        skv[3] = mk(14'h0BA1, 8'h01, 8'h00, 1, OP_DEC, 8'h01, 1, 1, 1, 0, 0);
        skv[4] = mk(14'h07A0, 8'h05, 8'h0A, 1, OP_ADD, 8'h05, 1, 0, 0, 0, 0);
        skv[5] = mk(14'h0BA1, 8'h01, 8'h00, 1, OP_DEC, 8'h01, 1, 1, 1, 0, 0);
        skv[6] = mk(14'h0FA2, 8'hFF, 8'h00, 1, OP_INC, 8'hFF, 1, 0, 0, 0, 0);
        skv[7] = mk(14'h3E01, 8'h00, 8'h02, 1, OP_ADD, 8'h01, 0, 0, 1, 1, 0);

        bus.instr = '0; bus.instr_valid = 1'b0; bus.rf_rd_data = '0; bus.alu_result = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({bus.instr_ready, bus.rf_addr, bus.rf_rd_en, bus.alu_op, bus.alu_lf,
                                     bus.alu_d, bus.alu_d_wr_en, bus.alu_status_wr_en, bus.unsupported}),
              32'h0100_0000);
        check("reset_retired", 32'(bus.retired), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(bus.instr_ready), 32'd1);

        for (int i = 0; i < 21; i++) begin
            issue(vecs[i]);
            check_vec($sformatf("v%0d", i), vecs[i]);
        end

        for (int i = 0; i < 8; i++) begin
            issue(skv[i]);
            check_vec($sformatf("skip%0d", i), skv[i]);
        end

        // Valid held high for three instructions: ready only in Q4 slots, no IDLE gap
        @(negedge clk);
        bus.instr = 14'h3E01; bus.alu_result = 8'h01; bus.instr_valid = 1'b1;
        acc = 0;
        rmask = '0;
        for (int c = 0; c < 14; c++) begin
            rmask[c] = bus.instr_ready;
            if (bus.instr_ready && bus.instr_valid) acc++;
            @(posedge clk);
            #1 if (acc == 3) bus.instr_valid = 1'b0;
            @(negedge clk);
        end
        check("b2b_ready_mask", 32'(rmask), 32'(14'b11_0001_0001_0001));
        check("b2b_accepts", 32'(acc), 32'd3);
        exp_ret = exp_ret + 16'd3;
        check("b2b_retired", 32'(bus.retired), 32'(exp_ret));

        // Reset asserted in Q3 of ADDWF aborts it without any write strobe
        bus.instr = 14'h07A0; bus.rf_rd_data = 8'h05; bus.alu_result = 8'h0A; bus.instr_valid = 1'b1;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", 32'({bus.instr_ready, bus.rf_addr, bus.rf_rd_en, bus.alu_op, bus.alu_lf,
                                      bus.alu_d, bus.alu_d_wr_en, bus.alu_status_wr_en, bus.unsupported}),
              32'h0100_0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_ret = 16'd0;
        wr_seen = 1'b0;
        rdy_all = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            wr_seen = wr_seen | bus.alu_d_wr_en | bus.alu_status_wr_en;
            rdy_all = rdy_all & bus.instr_ready;
        end
        check("midrst_no_strobe", 32'(wr_seen), 32'd0);
        check("midrst_idle", 32'(rdy_all), 32'd1);
        check("midrst_retired", 32'(bus.retired), 32'd0);

        issue(vecs[0]);
        check_vec("post_rst_addwf", vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
